// File: rtl/dma_ring_scheduler_if.sv
// Descriptor and completion-status channels shared by the ring scheduler and the DMA engine.
// The scheduler takes the master side: it issues descriptors and receives status.
interface dma_ring_scheduler_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int LEN_WIDTH      = 16
) ();
    logic [AXI_ADDR_WIDTH-1:0] m_axis_desc_addr;
    logic [LEN_WIDTH-1:0]      m_axis_desc_len;
    logic                      m_axis_desc_tvalid;
    logic                      m_axis_desc_tready;
    logic [LEN_WIDTH-1:0]      s_axis_status_len;
    logic                      s_axis_status_error;
    logic                      s_axis_status_tvalid;

    modport master (
        output m_axis_desc_addr, m_axis_desc_len, m_axis_desc_tvalid,
        input  m_axis_desc_tready,
        input  s_axis_status_len, s_axis_status_error, s_axis_status_tvalid
    );

    modport slave (
        input  m_axis_desc_addr, m_axis_desc_len, m_axis_desc_tvalid,
        output m_axis_desc_tready,
        output s_axis_status_len, s_axis_status_error, s_axis_status_tvalid
    );
endinterface

// File: rtl/dma_ring_scheduler.sv
// Receive-ring scheduler: hands out one buffer descriptor per free slot, records completion
// lengths per slot, and frees slots oldest-first on release pulses.
module dma_ring_scheduler #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int LEN_WIDTH      = 16,
    parameter int SLOT_WIDTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [AXI_ADDR_WIDTH-1:0] cfg_base_adr,
    input  logic [LEN_WIDTH-1:0]      cfg_slot_size,
    input  logic [SLOT_WIDTH-1:0]     cfg_slot_count,
    dma_ring_scheduler_if.master      bus,
    input  logic                      release_i,
    output logic [SLOT_WIDTH-1:0]     fill_level,
    output logic [SLOT_WIDTH-1:0]     rd_index,
    output logic [LEN_WIDTH-1:0]      rd_len,
    output logic                      error_flag
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_FULL  = 2'd3;

    localparam logic [SLOT_WIDTH-1:0] ONE_S = {{(SLOT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]                state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] base_q, base_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]      size_q, size_d;
    logic [SLOT_WIDTH-1:0]     cnt_q, cnt_d;
    logic [SLOT_WIDTH-1:0]     wr_q, wr_d;
    logic [SLOT_WIDTH-1:0]     rd_q, rd_d;
    logic [SLOT_WIDTH-1:0]     fill_q, fill_d;
    logic                      err_q, err_d;

    logic [LEN_WIDTH-1:0] len_mem [0:(1<<SLOT_WIDTH)-1];

    logic                  status_fire;
    logic                  release_fire;
    logic                  wr_last;
    logic                  rd_last;
    logic [SLOT_WIDTH-1:0] fill_adj;

    assign status_fire  = (state_q == S_WAIT) && bus.s_axis_status_tvalid;
    assign release_fire = release_i && (fill_q != '0);
    assign wr_last      = (wr_q == cnt_q - ONE_S);
    assign rd_last      = (rd_q == cnt_q - ONE_S);

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        addr_d   = addr_q;
        size_d   = size_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        err_d    = err_q;
        fill_adj = fill_q;

        // Simultaneous fill and release cancel out in the occupancy count.
        if (status_fire && !release_fire)
            fill_adj = fill_q + ONE_S;
        else if (!status_fire && release_fire)
            fill_adj = fill_q - ONE_S;
        fill_d = fill_adj;

        if (status_fire) begin
            wr_d   = wr_last ? '0 : wr_q + ONE_S;
            addr_d = wr_last ? base_q : addr_q + AXI_ADDR_WIDTH'(size_q);
            err_d  = err_q | bus.s_axis_status_error;
        end
        if (release_fire)
            rd_d = rd_last ? '0 : rd_q + ONE_S;

        case (state_q)
            S_IDLE: begin
                if (enable && (cfg_slot_count != '0)) begin
                    state_d = S_ISSUE;
                    base_d  = cfg_base_adr;
                    addr_d  = cfg_base_adr;
                    size_d  = cfg_slot_size;
                    cnt_d   = cfg_slot_count;
                    wr_d    = '0;
                    rd_d    = '0;
                    fill_d  = '0;
                    err_d   = 1'b0;
                end
            end
            S_ISSUE: begin
                if (bus.m_axis_desc_tready)
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                if (status_fire) begin
                    if (!enable)
                        state_d = S_IDLE;
                    else if (fill_adj == cnt_q)
                        state_d = S_FULL;
                    else
                        state_d = S_ISSUE;
                end
            end
            S_FULL: begin
                if (!enable)
                    state_d = S_IDLE;
                else if (release_fire)
                    state_d = S_ISSUE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            cnt_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            fill_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            fill_q  <= fill_d;
            err_q   <= err_d;
        end
    end

    // Length table holds only data; readers never look at a slot before it is filled.
    always_ff @(posedge clk) begin
        if (status_fire)
            len_mem[wr_q] <= bus.s_axis_status_len;
    end

    assign bus.m_axis_desc_tvalid = (state_q == S_ISSUE);
    assign bus.m_axis_desc_addr   = addr_q;
    assign bus.m_axis_desc_len    = size_q;
    assign fill_level             = fill_q;
    assign rd_index               = rd_q;
    assign rd_len                 = len_mem[rd_q];
    assign error_flag             = err_q;

endmodule

// File: tb/tb_dma_ring_scheduler.sv
// Bench for dma_ring_scheduler: directed ring scenarios plus randomized rings checked
// against a slot-occupancy reference model; descriptors are checked by a scoreboard monitor.
module tb_dma_ring_scheduler;
    localparam int AW = 32;
    localparam int LW = 16;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          release_i = 1'b0;
    logic [AW-1:0] cfg_base_adr = '0;
    logic [LW-1:0] cfg_slot_size = '0;
    logic [SW-1:0] cfg_slot_count = '0;
    logic [SW-1:0] fill_level;
    logic [SW-1:0] rd_index;
    logic [LW-1:0] rd_len;
    logic          error_flag;

    dma_ring_scheduler_if #(.AXI_ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    dma_ring_scheduler #(.AXI_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .SLOT_WIDTH(SW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .cfg_base_adr   (cfg_base_adr),
        .cfg_slot_size  (cfg_slot_size),
        .cfg_slot_count (cfg_slot_count),
        .bus            (bus.master),
        .release_i      (release_i),
        .fill_level     (fill_level),
        .rd_index       (rd_index),
        .rd_len         (rd_len),
        .error_flag     (error_flag)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [AW-1:0] exp_addr_q [$];
    logic [LW-1:0] exp_len_q  [$];

    // Reference model: ring geometry, next slot to fill, and FIFO of filled slot lengths.
    logic [AW-1:0] m_base;
    logic [LW-1:0] m_size;
    int            m_cnt = 1;
    int            m_wr  = 0;
    logic [LW-1:0] m_lens [$];
    bit            m_err = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] slot_addr(input int slot);
        logic [63:0] t;
        t = 64'(m_base) + 64'(slot) * 64'(m_size);
        return t[AW-1:0];
    endfunction

    function automatic int rd_model();
        return (m_wr + m_cnt - m_lens.size()) % m_cnt;
    endfunction

    task automatic expect_desc();
        exp_addr_q.push_back(slot_addr(m_wr));
        exp_len_q.push_back(m_size);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_n && bus.m_axis_desc_tvalid && bus.m_axis_desc_tready) begin
                if (exp_addr_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_desc: got addr 0x%0h, required no descriptor", bus.m_axis_desc_addr);
                end else begin
                    chk("desc_addr", bus.m_axis_desc_addr, exp_addr_q.pop_front());
                    chk("desc_len", bus.m_axis_desc_len, exp_len_q.pop_front());
                end
            end
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_fill"}, fill_level, m_lens.size());
        chk({tag, "_rd_index"}, rd_index, rd_model());
        chk({tag, "_error"}, error_flag, m_err);
        if (m_lens.size() > 0)
            chk({tag, "_rd_len"}, rd_len, m_lens[0]);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tvalid"}, bus.m_axis_desc_tvalid, 0);
        chk({tag, "_addr"}, bus.m_axis_desc_addr, 0);
        chk({tag, "_len"}, bus.m_axis_desc_len, 0);
        chk({tag, "_fill"}, fill_level, 0);
        chk({tag, "_rd_index"}, rd_index, 0);
        chk({tag, "_error"}, error_flag, 0);
    endtask

    task automatic handshake(input int stall, input bit drop_en);
        int w = 0;
        logic [AW-1:0] a0;
        while (!bus.m_axis_desc_tvalid && w < 50) begin
            tick();
            w++;
        end
        chk("tvalid_timeout", bus.m_axis_desc_tvalid, 1);
        a0 = bus.m_axis_desc_addr;
        for (int i = 0; i < stall; i++) begin
            if (drop_en && i == stall / 2)
                enable = 1'b0;
            tick();
            chk("stall_tvalid", bus.m_axis_desc_tvalid, 1);
            chk("stall_addr", bus.m_axis_desc_addr, a0);
        end
        bus.m_axis_desc_tready = 1'b1;
        tick();
        bus.m_axis_desc_tready = 1'b0;
    endtask

    task automatic do_txn(input logic [LW-1:0] len, input bit err, input bit rel,
                          input int stall, input int gap, input bit drop_en);
        bit r;
        expect_desc();
        handshake(stall, drop_en);
        repeat (gap) tick();
        r = rel && (m_lens.size() > 0);
        bus.s_axis_status_len    = len;
        bus.s_axis_status_error  = err;
        bus.s_axis_status_tvalid = 1'b1;
        release_i                = r;
        tick();
        bus.s_axis_status_tvalid = 1'b0;
        bus.s_axis_status_error  = 1'b0;
        release_i                = 1'b0;
        if (r)
            void'(m_lens.pop_front());
        m_lens.push_back(len);
        m_wr  = (m_wr + 1) % m_cnt;
        m_err = m_err | err;
    endtask

    task automatic do_release();
        release_i = 1'b1;
        tick();
        release_i = 1'b0;
        if (m_lens.size() > 0)
            void'(m_lens.pop_front());
    endtask

    task automatic start_ring(input logic [AW-1:0] base, input logic [LW-1:0] size, input int cnt);
        m_base = base;
        m_size = size;
        m_cnt  = cnt;
        m_wr   = 0;
        m_err  = 1'b0;
        m_lens.delete();
        cfg_base_adr   = base;
        cfg_slot_size  = size;
        cfg_slot_count = SW'(cnt);
        enable         = 1'b1;
        tick();
        // Configuration churn while running must not reach the active ring.
        cfg_base_adr   = $urandom;
        cfg_slot_size  = LW'($urandom);
        cfg_slot_count = SW'($urandom_range(1, 15));
    endtask

    task automatic stop_ring();
        if (m_lens.size() < m_cnt) begin
            enable = 1'b0;
            do_txn(LW'($urandom), 1'b0, 1'b0, 0, 0, 1'b0);
        end else begin
            enable = 1'b0;
            tick();
        end
        repeat (3) tick();
        chk("stop_tvalid", bus.m_axis_desc_tvalid, 0);
        check_state("stop");
    endtask

    initial begin
        bus.m_axis_desc_tready   = 1'b0;
        bus.s_axis_status_len    = '0;
        bus.s_axis_status_error  = 1'b0;
        bus.s_axis_status_tvalid = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) tick();
        check_reset_outputs("por");
        rst_n = 1'b1;
        tick();

        // Three-slot ring fills up, then wraps after one release.
        start_ring(32'h1000_0000, 16'h0800, 3);
        do_release();
        chk("rel_empty_fill", fill_level, 0);
        chk("rel_empty_rd", rd_index, 0);
        for (int i = 0; i < 3; i++)
            do_txn(LW'(16'h100 + i), 1'b0, 1'b0, 0, 1, 1'b0);
        tick();
        chk("full_fill", fill_level, 3);
        chk("full_tvalid", bus.m_axis_desc_tvalid, 0);
        tick();
        chk("full_tvalid_hold", bus.m_axis_desc_tvalid, 0);
        do_release();
        chk("after_rel_fill", fill_level, 2);
        chk("after_rel_rd", rd_index, 1);
        chk("wrap_addr", bus.m_axis_desc_addr, 32'h1000_0000);
        do_txn(16'h0200, 1'b0, 1'b0, 0, 0, 1'b0);
        check_state("wrap");
        stop_ring();

        // Long tready stall with enable dropped part-way through.
        start_ring(32'h2000_0000, 16'h0100, 4);
        do_txn(16'h0020, 1'b0, 1'b0, 10, 1, 1'b1);
        repeat (3) tick();
        chk("drop_en_idle_tvalid", bus.m_axis_desc_tvalid, 0);
        check_state("drop_en");
        chk("drop_en_q_empty", exp_addr_q.size(), 0);

        // Error status, coincident status and release, then reset mid-WAIT.
        start_ring(32'h3000_0000, 16'h0040, 4);
        do_txn(16'h0040, 1'b1, 1'b0, 0, 0, 1'b0);
        chk("err_set", error_flag, 1);
        chk("err_rd_len", rd_len, 16'h0040);
        do_txn(16'h0055, 1'b0, 1'b1, 0, 1, 1'b0);
        chk("both_fill", fill_level, 1);
        chk("both_rd", rd_index, 1);
        chk("err_sticky", error_flag, 1);
        check_state("both");
        expect_desc();
        handshake(0, 1'b0);
        rst_n = 1'b0;
        #2;
        check_reset_outputs("midwait_rst");
        enable = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        bus.s_axis_status_len    = 16'h0077;
        bus.s_axis_status_tvalid = 1'b1;
        tick();
        bus.s_axis_status_tvalid = 1'b0;
        tick();
        check_reset_outputs("late_status");

        // Randomized rings, including address wrap modulo 2^32.
        for (int p = 0; p < 4; p++) begin
            start_ring($urandom, LW'($urandom_range(1, 16'hffff)), $urandom_range(1, 15));
            check_state("rnd_start");
            for (int it = 0; it < 60; it++) begin
                if (m_lens.size() == m_cnt || (m_lens.size() > 0 && $urandom_range(0, 3) == 0))
                    do_release();
                else
                    do_txn(LW'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                           $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
                check_state("rnd");
            end
            stop_ring();
        end

        repeat (3) tick();
        chk("exp_queue_empty", exp_addr_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dma_ring_scheduler.md
DMA_RING_SCHEDULER -- requirements
Module: dma_ring_scheduler

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 32: width of DMA buffer addresses.
REQ-002 SHALL have parameter LEN_WIDTH, default 16: width of slot size and transfer length.
REQ-003 SHALL have parameter SLOT_WIDTH, default 4: width of slot index and count; maximum 2^SLOT_WIDTH-1 slots.
REQ-004 SHALL have port clk  input  1: the single clock.
REQ-005 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port enable  input  1: run ring when high; level-sensitive.
REQ-007 SHALL have port cfg_base_adr  input  AXI_ADDR_WIDTH: address of slot 0.
REQ-008 SHALL have port cfg_slot_size  input  LEN_WIDTH: byte stride and maximum length per slot.
REQ-009 SHALL have port cfg_slot_count  input  SLOT_WIDTH: number of slots; 0 means no descriptors are issued.
REQ-010 SHALL have port m_axis_desc_addr  output  AXI_ADDR_WIDTH: descriptor buffer address.
REQ-011 SHALL have port m_axis_desc_len  output  LEN_WIDTH: descriptor maximum length, always the latched cfg_slot_size.
REQ-012 SHALL have port m_axis_desc_tvalid  output  1 and m_axis_desc_tready  input  1: descriptor handshake.
REQ-013 SHALL have port s_axis_status_len  input  LEN_WIDTH, s_axis_status_error  input  1, s_axis_status_tvalid  input  1: completion status; always accepted, no ready.
REQ-014 SHALL have port release  input  1: single-cycle pulse freeing the oldest filled slot.
REQ-015 SHALL have ports fill_level  output  SLOT_WIDTH, rd_index  output  SLOT_WIDTH, rd_len  output  LEN_WIDTH, error_flag  output  1: filled-slot count, oldest filled slot index, its received length, sticky error.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, FULL.
REQ-017 IDLE -> ISSUE when enable=1 and cfg_slot_count!=0; on this transition SHALL latch cfg_*, set wr_index=0, rd_index=0, fill_level=0, error_flag=0, desc address=cfg_base_adr.
REQ-018 ISSUE SHALL hold m_axis_desc_tvalid=1 with stable addr/len until tready; on handshake -> WAIT.
REQ-019 WAIT SHALL ignore nothing: on status_tvalid store status_len into length table at wr_index, OR status_error into error_flag, increment fill_level, advance wr_index.
REQ-020 wr_index advance SHALL wrap from latched count-1 to 0; descriptor address SHALL advance by adding slot_size (accumulator, no multiplier) and reload cfg_base_adr on wrap; address addition SHALL truncate modulo 2^AXI_ADDR_WIDTH.
REQ-021 After status in WAIT: -> IDLE if enable=0; else -> FULL if new fill_level==latched count; else -> ISSUE on the next cycle (one idle cycle between descriptors minimum).
REQ-022 FULL -> ISSUE when a release decrements fill_level; FULL -> IDLE if enable=0.
REQ-023 enable deasserted in ISSUE SHALL NOT drop tvalid; the outstanding descriptor completes through WAIT, then -> IDLE.
REQ-024 release with fill_level>0 SHALL decrement fill_level and advance rd_index with wrap at count-1; release with fill_level=0 SHALL be ignored.
REQ-025 Status and release in the same cycle SHALL leave fill_level unchanged while both indices advance.
REQ-026 status_tvalid outside WAIT SHALL be ignored.
REQ-027 rd_len SHALL combinationally show the length table entry at rd_index.
REQ-028 cfg_* changes while not in IDLE SHALL have no effect until the next IDLE exit.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, m_axis_desc_tvalid=0, fill_level=0, wr_index=0, rd_index=0, error_flag=0, m_axis_desc_addr=0, m_axis_desc_len=0; length table contents need not reset.
REQ-030 Reset mid-transfer SHALL abandon the outstanding descriptor; late statuses after reset SHALL be ignored (IDLE).

Verification
REQ-031 base=0x1000_0000, size=0x800, count=3, enable=1, tready=1, status each 2 cycles after issue -> addrs 0x1000_0000, 0x1000_0800, 0x1000_1000, then FULL with fill_level=3, tvalid=0.
REQ-032 From FULL, one release -> fill_level=2, rd_index=1, next descriptor addr 0x1000_0000 (wrap).
REQ-033 tready held low 10 cycles in ISSUE -> tvalid and addr stable all 10 cycles; enable dropped meanwhile -> handshake, status, then IDLE.
REQ-034 Status and release same cycle with fill_level=1 -> fill_level stays 1, rd_index and wr_index each advance; release at fill_level=0 -> no change.
REQ-035 Status with error=1, len=0x40 -> error_flag=1 sticky, rd_len=0x40 at that slot; rst_n pulse mid-WAIT -> all outputs at reset values next edge-free sample.
